// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, writeback result-select
// encodings and load funct3 codes.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// M-to-W pipeline bus: memory-stage results and stall/flush controls in,
// register-file write port and W-stage status out.
interface wb_stage_if #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
);
  logic              stall_w;
  logic              flush_w;
  logic              valid_m;
  logic              regwrite_m;
  logic [1:0]        resultsrc_m;
  logic [2:0]        funct3_m;
  logic [REG_AW-1:0] rd_m;
  logic [XLEN-1:0]   aluresult_m;
  logic [XLEN-1:0]   readdata_m;
  logic [XLEN-1:0]   pcplus4_m;

  logic              valid_w;
  logic              regwrite_w;
  logic [REG_AW-1:0] rd_w;
  logic [XLEN-1:0]   result_w;

  modport master (
    output stall_w, flush_w, valid_m, regwrite_m, resultsrc_m, funct3_m,
           rd_m, aluresult_m, readdata_m, pcplus4_m,
    input  valid_w, regwrite_w, rd_w, result_w
  );

  modport slave (
    input  stall_w, flush_w, valid_m, regwrite_m, resultsrc_m, funct3_m,
           rd_m, aluresult_m, readdata_m, pcplus4_m,
    output valid_w, regwrite_w, rd_w, result_w
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: picks the addressed byte/halfword from an aligned
// little-endian word and sign- or zero-extends it according to funct3.
module load_ext
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    byte_sel = word[7:0];
    ext      = word;
    unique case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback select; drives the register file
// write port. Optional retired-instruction counter under WB_INSTRET_EN.
module wb_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_stage_if.slave   wb
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  logic              valid_q,     valid_d;
  logic              regwrite_q,  regwrite_d;
  logic [1:0]        resultsrc_q, resultsrc_d;
  logic [2:0]        funct3_q,    funct3_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic [XLEN-1:0]   alu_q,       alu_d;
  logic [XLEN-1:0]   rdata_q,     rdata_d;
  logic [XLEN-1:0]   pc4_q,       pc4_d;
  logic [XLEN-1:0]   load_val;

  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    resultsrc_d = resultsrc_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    pc4_d       = pc4_q;
    if (wb.flush_w) begin
      // Bubble only needs the control bits cleared; data fields are dead.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!wb.stall_w) begin
      valid_d     = wb.valid_m;
      regwrite_d  = wb.regwrite_m;
      resultsrc_d = wb.resultsrc_m;
      funct3_d    = wb.funct3_m;
      rd_d        = wb.rd_m;
      alu_d       = wb.aluresult_m;
      rdata_d     = wb.readdata_m;
      pc4_d       = wb.pcplus4_m;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      pc4_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      pc4_q       <= pc4_d;
    end
  end

  load_ext u_load_ext (
    .word   (rdata_q),
    .offset (alu_q[1:0]),
    .funct3 (funct3_q),
    .ext    (load_val)
  );

  always_comb begin
    wb.valid_w    = valid_q;
    wb.regwrite_w = valid_q & regwrite_q & (rd_q != '0);
    wb.rd_w       = rd_q;
    case (resultsrc_q)
      RES_LOAD: wb.result_w = load_val;
      RES_PC4:  wb.result_w = pc4_q;
      default:  wb.result_w = alu_q;
    endcase
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Retirement is judged on the W instruction leaving, so a same-cycle
  // flush (which only affects the incoming slot) does not cancel it.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && !wb.stall_w) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the pipelined RV32I core.
- Captures the memory-stage results and extracts and sign- or zero-extends load data.
- Selects the writeback result and drives the register file write port (write enable, write address, write data).
- It is the writer side of the register file. It also exports the W-stage destination and enable to the hazard/forwarding unit.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  core clock, rising-edge active.
- reset_n  in  1  asynchronous, active-low reset.
- stall_w  in  1  hold the W register contents.
- flush_w  in  1  insert a bubble into W.
- valid_m  in  1  M-stage instruction is valid.
- regwrite_m  in  1  M-stage instruction writes rd.
- resultsrc_m  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved (selects ALU).
- funct3_m  in  3  load size/sign code.
- rd_m  in  REG_AW  destination register.
- aluresult_m  in  XLEN  ALU result or load address.
- readdata_m  in  XLEN  raw aligned word from data memory.
- pcplus4_m  in  XLEN  PC+4 value.
- valid_w  out  1  W stage holds a valid instruction.
- regwrite_w  out  1  to regfile we3.
- rd_w  out  REG_AW  to regfile a3.
- result_w  out  XLEN  to regfile wd3 and the forwarding mux.

Behaviour:
- Reset (reset_n low, asynchronous): all W registers clear to 0; valid_w=0, regwrite_w=0, rd_w=0, result_w=0.
- Register update on each rising clk edge:
  - flush_w=1: valid and regwrite registers clear; other fields are don't-care. Flush has priority over stall.
  - else stall_w=1: all W registers hold.
  - else: capture valid_m, regwrite_m, resultsrc_m, funct3_m, rd_m, aluresult_m, readdata_m, pcplus4_m.
- Latency: one cycle from the M inputs to the W outputs.
- result_w is combinational from the W registers, so the register file's same-cycle bypass makes it visible to D-stage reads in the same cycle.
- regwrite_w = valid_w & regwrite_reg & (rd_w != 0). Writes to x0 are never issued.
- Load extraction uses byte offset off = aluresult_w[1:0]:
  - funct3 000 LB: sign-extend byte[off].
  - funct3 100 LBU: zero-extend byte[off].
  - funct3 001 LH: sign-extend halfword[off[1]]; off[0] is ignored.
  - funct3 101 LHU: zero-extend halfword[off[1]]; off[0] is ignored.
  - funct3 010 LW: full word; offset is ignored.
  - funct3 011/110/111: full word.
- Byte order is little-endian: byte0 = bits[7:0].
- result_w: resultsrc 00 -> aluresult_w; 01 -> extracted load data; 10 -> pcplus4_w; 11 -> aluresult_w.
- Under a sustained stall, the same write is reissued every cycle. This is idempotent.
- When valid_w=0, regwrite_w=0 regardless of the other fields.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined:
  - Adds output instret (64 bits), reset to 0.
  - instret increments by 1 on each rising edge where valid_w=1 and stall_w=0 (retirement).
  - A flush in that same cycle does not suppress the count of the retiring instruction.
  - Wraps from 2^64-1 to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rv_pkg:
  - resultsrc encoding constants (RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN.
- One sub-module, load_ext: purely combinational. Inputs are word, offset[1:0], funct3; output is the extended XLEN value.

Test Plan:
- Reset mid-stream: assert reset_n=0 while valid_w=1 and regwrite_w=1 -> all outputs go to 0 immediately, with no clk edge required.
- LB at offset 3: readdata=0x80FF_1234, aluresult=0x1003, funct3=000, rd=5 -> one cycle later regwrite_w=1, rd_w=5, result_w=0xFFFF_FF80.
- LHU and LH at offset 2: readdata=0x8001_0000 -> LHU gives result_w=0x0000_8001; LH gives 0xFFFF_8001.
- x0 suppression and JAL: regwrite_m=1, rd_m=0 -> regwrite_w=0. With rd_m=1, resultsrc=10, pcplus4=0x0000_0104 -> result_w=0x0000_0104.
- Stall then flush: capture ALU result 0xDEAD_BEEF, then stall_w=1 for 3 cycles -> outputs hold. Then assert flush_w and stall_w together -> valid_w=0 and regwrite_w=0 next cycle.
- WB_INSTRET_EN defined: 5 valid instructions, with 2 stall cycles interleaved -> instret=5. A preloaded 0xFFFF_FFFF_FFFF_FFFF wraps to 0 after one retirement.
